// File: rtl/alu_mc.sv
// alu_mc: multi-cycle ALU with valid/ready on both sides and an iterative shift-add multiply.
// Optional: define ALU_MUL_EARLY_EXIT_EN to end a multiply as soon as the remaining multiplier bits are zero.
module alu_mc #(
  parameter int DATA_WIDTH = 32,
  parameter int CNT_WIDTH  = $clog2(DATA_WIDTH) + 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] A,
  input  logic [DATA_WIDTH-1:0] B,
  input  logic [2:0]            ALUop,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] Result,
  output logic                  Overflow,
  output logic                  CarryOut,
  output logic                  Zero
);
  localparam int W = DATA_WIDTH;

  localparam logic [2:0] OP_AND  = 3'b000;
  localparam logic [2:0] OP_OR   = 3'b001;
  localparam logic [2:0] OP_ADD  = 3'b010;
  localparam logic [2:0] OP_XOR  = 3'b011;
  localparam logic [2:0] OP_MUL  = 3'b100;
  localparam logic [2:0] OP_SLTU = 3'b101;
  localparam logic [2:0] OP_SUB  = 3'b110;
  localparam logic [2:0] OP_SLT  = 3'b111;

  localparam logic [CNT_WIDTH-1:0] LAST_ITER = CNT_WIDTH'(W - 1);

  typedef enum logic [1:0] {S_IDLE, S_MUL, S_HOLD} state_t;

  typedef struct packed {
    logic [W-1:0] res;
    logic         ovf;
    logic         cy;
    logic         z;
  } rsp_t;

  state_t               r_state;
  rsp_t                 r_rsp;
  logic                 r_out_valid;
  logic [2*W-1:0]       r_mcand;
  logic [2*W-1:0]       r_acc;
  logic [W-1:0]         r_mplier;
  logic [CNT_WIDTH-1:0] r_cnt;

  logic                 w_accept;
  logic [W:0]           w_sum;
  logic [W:0]           w_dif;
  logic                 w_add_ovf;
  logic                 w_sub_ovf;
  logic                 w_slt;
  logic [W-1:0]         w_mplier_nxt;
  logic                 w_mul_done;
  rsp_t                 w_rsp;

  assign in_ready = (r_state == S_IDLE) && (!r_out_valid || out_ready);
  assign w_accept = in_valid && in_ready;

  // One adder for ADD and one subtractor shared by SUB/SLT/SLTU.
  assign w_sum     = {1'b0, A} + {1'b0, B};
  assign w_dif     = {1'b0, A} + {1'b0, ~B} + {{W{1'b0}}, 1'b1};
  assign w_add_ovf = (A[W-1] == B[W-1]) && (w_sum[W-1] != A[W-1]);
  assign w_sub_ovf = (A[W-1] != B[W-1]) && (w_dif[W-1] != A[W-1]);
  assign w_slt     = w_dif[W-1] ^ w_sub_ovf;

  always_comb begin
    w_rsp = '0;
    case (ALUop)
      OP_AND: w_rsp.res = A & B;
      OP_OR:  w_rsp.res = A | B;
      OP_XOR: w_rsp.res = A ^ B;
      OP_ADD: begin
        w_rsp.res = w_sum[W-1:0];
        w_rsp.cy  = w_sum[W];
        w_rsp.ovf = w_add_ovf;
      end
      OP_SUB: begin
        w_rsp.res = w_dif[W-1:0];
        w_rsp.cy  = w_dif[W];
        w_rsp.ovf = w_sub_ovf;
      end
      OP_SLT: begin
        w_rsp.res = {{(W-1){1'b0}}, w_slt};
        w_rsp.cy  = w_dif[W];
      end
      OP_SLTU: begin
        w_rsp.res = {{(W-1){1'b0}}, ~w_dif[W]};
        w_rsp.cy  = w_dif[W];
      end
      default: w_rsp.res = '0;  // OP_MUL result comes from the iterative path
    endcase
    w_rsp.z = (w_rsp.res == '0);
  end

  assign w_mplier_nxt = r_mplier >> 1;

`ifdef ALU_MUL_EARLY_EXIT_EN
  assign w_mul_done = (r_cnt == LAST_ITER) || (w_mplier_nxt == '0);
`else
  assign w_mul_done = (r_cnt == LAST_ITER);
`endif

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state     <= S_IDLE;
      r_rsp       <= '0;
      r_out_valid <= 1'b0;
      r_mcand     <= '0;
      r_acc       <= '0;
      r_mplier    <= '0;
      r_cnt       <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            if (ALUop == OP_MUL) begin
              // Accept implies any held result is retiring now or was already gone.
              r_mcand     <= {{W{1'b0}}, A};
              r_mplier    <= B;
              r_acc       <= '0;
              r_cnt       <= '0;
              r_out_valid <= 1'b0;
              r_state     <= S_MUL;
            end else begin
              r_rsp       <= w_rsp;
              r_out_valid <= 1'b1;
            end
          end else if (out_ready) begin
            r_out_valid <= 1'b0;
          end
        end
        S_MUL: begin
          if (r_mplier[0]) r_acc <= r_acc + r_mcand;
          r_mcand  <= r_mcand << 1;
          r_mplier <= w_mplier_nxt;
          r_cnt    <= r_cnt + CNT_WIDTH'(1);
          if (w_mul_done) r_state <= S_HOLD;
        end
        S_HOLD: begin
          r_rsp.res   <= r_acc[W-1:0];
          r_rsp.ovf   <= |r_acc[2*W-1:W];
          r_rsp.cy    <= 1'b0;
          r_rsp.z     <= (r_acc[W-1:0] == '0);
          r_out_valid <= 1'b1;
          r_state     <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign out_valid = r_out_valid;
  assign Result    = r_rsp.res;
  assign Overflow  = r_rsp.ovf;
  assign CarryOut  = r_rsp.cy;
  assign Zero      = r_rsp.z;

endmodule

// File: tb/tb_alu_mc.sv
// tb_alu_mc: table-driven vectors plus handshake/latency/reset sequences, checked by a result scoreboard.
module tb_alu_mc;
  localparam int W = 32;

  typedef struct packed {
    logic [2:0]   op;
    logic [W-1:0] res;
    logic         ovf;
    logic         cy;
    logic         z;
  } exp_t;

  typedef struct {
    logic [2:0]   op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    exp_t         e;
  } vec_t;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] A;
  logic [W-1:0] B;
  logic [2:0]   ALUop;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] Result;
  logic         Overflow;
  logic         CarryOut;
  logic         Zero;

  int   n_chk = 0;
  int   n_fail = 0;
  exp_t exp_q[$];
  vec_t vecs[$];
  int   cur_run = 0;
  int   last_run = 0;

  alu_mc #(.DATA_WIDTH(W)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .A(A), .B(B), .ALUop(ALUop), .out_valid(out_valid), .out_ready(out_ready),
    .Result(Result), .Overflow(Overflow), .CarryOut(CarryOut), .Zero(Zero)
  );

  always #5 clk = ~clk;

  function automatic exp_t mk(input logic [2:0] op, input logic [W-1:0] res,
                              input logic ovf, input logic cy, input logic z);
    exp_t e;
    e.op = op; e.res = res; e.ovf = ovf; e.cy = cy; e.z = z;
    return e;
  endfunction

  // Reference model using wide signed/unsigned arithmetic.
  function automatic exp_t model(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    exp_t        e;
    longint      sa, sb, sr;
    logic [63:0] p;
    e = '0;
    e.op = op;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    case (op)
      3'd0: e.res = a & b;
      3'd1: e.res = a | b;
      3'd3: e.res = a ^ b;
      3'd2: begin
        p = {32'b0, a} + {32'b0, b};
        e.res = p[31:0]; e.cy = p[32];
        sr = sa + sb;
        e.ovf = (sr < -64'sd2147483648) || (sr > 64'sd2147483647);
      end
      3'd6: begin
        e.res = a - b; e.cy = (a >= b);
        sr = sa - sb;
        e.ovf = (sr < -64'sd2147483648) || (sr > 64'sd2147483647);
      end
      3'd7: begin e.res = {31'b0, (sa < sb)}; e.cy = (a >= b); end
      3'd5: begin e.res = {31'b0, (a < b)};   e.cy = (a >= b); end
      default: begin
        p = {32'b0, a} * {32'b0, b};
        e.res = p[31:0]; e.ovf = |p[63:32];
      end
    endcase
    e.z = (e.res == '0);
    return e;
  endfunction

  function automatic int mul_lat(input logic [W-1:0] b);
    int it;
    it = W;
`ifdef ALU_MUL_EARLY_EXIT_EN
    it = 1;
    for (int i = 1; i < W; i++) if ((b >> i) != '0) it = i + 1;
`endif
    if (b === 'x) it = 0;
    return it + 2;
  endfunction

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] expv);
    n_chk++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, expv);
    end
  endtask

  task automatic add_vec(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic [W-1:0] res, input logic ovf, input logic cy, input logic z);
    vec_t v;
    v.op = op; v.a = a; v.b = b; v.e = mk(op, res, ovf, cy, z);
    vecs.push_back(v);
  endtask

  // Called at posedge+1; returns at posedge+1 right after the accepting edge.
  task automatic issue(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                       input exp_t e, output int ncyc);
    logic acc;
    ncyc = 0;
    acc = 1'b0;
    in_valid = 1'b1; ALUop = op; A = a; B = b;
    do begin
      @(negedge clk); acc = in_ready;
      @(posedge clk); #1; ncyc++;
    end while (!acc && ncyc < 200);
    in_valid = 1'b0;
    if (acc) exp_q.push_back(e);
    else begin
      n_chk++; n_fail++;
      $display("FAIL issue_timeout: in_ready stayed 0 for %0d cycles, expected 1", ncyc);
    end
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 200) begin @(posedge clk); #1; n++; end
    if (exp_q.size() != 0) begin
      n_chk++; n_fail++;
      $display("FAIL drain_timeout: %0d results outstanding, expected 0", exp_q.size());
      exp_q.delete();
    end
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic mul_latency(input string nm, input logic [W-1:0] a, input logic [W-1:0] b,
                             input exp_t e);
    int lat, bad_rdy, nc;
    lat = 0; bad_rdy = 0;
    issue(3'd4, a, b, e, nc);
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      if (out_valid && lat == 0) lat = k;
      if (lat == 0 && in_ready) bad_rdy++;
      @(posedge clk); #1;
    end
    check({nm, "_latency"}, lat, mul_lat(b));
    check({nm, "_in_ready_low"}, bad_rdy, 0);
    drain();
  endtask

  // Scoreboard: every delivered result must match the oldest outstanding expectation.
  always @(negedge clk) begin : mon
    exp_t e;
    if (rst && out_valid) cur_run++;
    else begin
      if (cur_run != 0) last_run = cur_run;
      cur_run = 0;
    end
    if (rst && out_valid && out_ready) begin
      n_chk++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL scoreboard_unexpected: got res=%h with no result outstanding", Result);
      end else begin
        e = exp_q.pop_front();
        if ({Result, Overflow, CarryOut, Zero} !== {e.res, e.ovf, e.cy, e.z}) begin
          n_fail++;
          $display("FAIL result op=%0d: got res=%h ovf=%b cy=%b z=%b, expected res=%h ovf=%b cy=%b z=%b",
                   e.op, Result, Overflow, CarryOut, Zero, e.res, e.ovf, e.cy, e.z);
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: time limit reached, expected test completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int         nc, tot, bad, outs;
    logic [2:0] op;
    logic [W-1:0] a, b;
    logic [2:0] sc_ops [7];
    sc_ops = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd5, 3'd6, 3'd7};

    rst = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    A = '0; B = '0; ALUop = '0;

    //       op     A             B             Result        ovf   cy    z
    add_vec(3'd2, 32'hFFFFFFFF, 32'h00000001, 32'h00000000, 1'b0, 1'b1, 1'b1);
    add_vec(3'd6, 32'h80000000, 32'h00000001, 32'h7FFFFFFF, 1'b1, 1'b1, 1'b0);
    add_vec(3'd7, 32'hFFFFFFFF, 32'h00000001, 32'h00000001, 1'b0, 1'b1, 1'b0);
    add_vec(3'd5, 32'hFFFFFFFF, 32'h00000001, 32'h00000000, 1'b0, 1'b1, 1'b1);
    add_vec(3'd0, 32'hF0F0F0F0, 32'h0FF00FF0, 32'h00F000F0, 1'b0, 1'b0, 1'b0);
    add_vec(3'd1, 32'h00000000, 32'h00000000, 32'h00000000, 1'b0, 1'b0, 1'b1);
    add_vec(3'd3, 32'hA5A5A5A5, 32'hA5A5A5A5, 32'h00000000, 1'b0, 1'b0, 1'b1);
    add_vec(3'd2, 32'h7FFFFFFF, 32'h00000001, 32'h80000000, 1'b1, 1'b0, 1'b0);
    add_vec(3'd6, 32'h00000005, 32'h00000005, 32'h00000000, 1'b0, 1'b1, 1'b1);
    add_vec(3'd6, 32'h00000000, 32'h00000001, 32'hFFFFFFFF, 1'b0, 1'b0, 1'b0);
    add_vec(3'd7, 32'h00000001, 32'hFFFFFFFF, 32'h00000000, 1'b0, 1'b0, 1'b1);
    add_vec(3'd5, 32'h00000001, 32'hFFFFFFFF, 32'h00000001, 1'b0, 1'b0, 1'b0);
    add_vec(3'd7, 32'h80000000, 32'h7FFFFFFF, 32'h00000001, 1'b0, 1'b1, 1'b0);
    add_vec(3'd3, 32'hFFFF0000, 32'h00FFFF00, 32'hFF00FF00, 1'b0, 1'b0, 1'b0);
    add_vec(3'd0, 32'h12345678, 32'h00000000, 32'h00000000, 1'b0, 1'b0, 1'b1);
    add_vec(3'd1, 32'h12340000, 32'h00005678, 32'h12345678, 1'b0, 1'b0, 1'b0);
    add_vec(3'd4, 32'h00010000, 32'h00010000, 32'h00000000, 1'b1, 1'b0, 1'b1);
    add_vec(3'd4, 32'h00000003, 32'h00000005, 32'h0000000F, 1'b0, 1'b0, 1'b0);
    add_vec(3'd4, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000001, 1'b1, 1'b0, 1'b0);
    add_vec(3'd4, 32'h00000007, 32'h00000001, 32'h00000007, 1'b0, 1'b0, 1'b0);
    add_vec(3'd4, 32'h00012345, 32'h00000000, 32'h00000000, 1'b0, 1'b0, 1'b1);

    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_outputs", 64'({out_valid, Overflow, CarryOut, Zero, Result}), 64'd0);
    check("reset_in_ready", 64'(in_ready), 64'd1);
    @(posedge clk); #1;
    rst = 1'b1;

    foreach (vecs[i]) issue(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].e, nc);
    drain();

    // Single-cycle op: result valid the cycle after accept.
    issue(3'd2, 32'hFFFFFFFF, 32'h1, mk(3'd2, 32'h0, 1'b0, 1'b1, 1'b1), nc);
    @(negedge clk);
    check("add_latency_out_valid", 64'(out_valid), 64'd1);
    @(posedge clk); #1;
    drain();

    mul_latency("mul_big", 32'h00010000, 32'h00010000, mk(3'd4, 32'h0, 1'b1, 1'b0, 1'b1));
    mul_latency("mul_7x1", 32'h7, 32'h1, mk(3'd4, 32'h7, 1'b0, 1'b0, 1'b0));
    mul_latency("mul_x0", 32'h55, 32'h0, mk(3'd4, 32'h0, 1'b0, 1'b0, 1'b1));

    // Backpressure: held result stays stable, no accept until out_ready returns.
    out_ready = 1'b0;
    issue(3'd2, 32'd1, 32'd2, mk(3'd2, 32'd3, 1'b0, 1'b0, 1'b0), nc);
    in_valid = 1'b1; ALUop = 3'd6; A = 32'd10; B = 32'd3;
    bad = 0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      if ({out_valid, in_ready, Result, Overflow, CarryOut, Zero} !== {1'b1, 1'b0, 32'd3, 3'b000}) bad++;
      @(posedge clk); #1;
    end
    check("backpressure_hold", bad, 0);
    out_ready = 1'b1;
    @(negedge clk);
    check("backpressure_release_in_ready", 64'(in_ready), 64'd1);
    @(posedge clk); #1;
    if (in_ready === 1'b1 || 1) exp_q.push_back(mk(3'd6, 32'd7, 1'b0, 1'b1, 1'b0));
    in_valid = 1'b0;
    drain();

    // Streaming: back-to-back single-cycle ops.
    last_run = 0;
    tot = 0;
    for (int i = 0; i < 8; i++) begin
      op = sc_ops[$urandom_range(0, 6)];
      a  = $urandom;
      b  = (i == 3) ? a : $urandom;
      issue(op, a, b, model(op, a, b), nc);
      tot += nc;
    end
    drain();
    check("stream_accept_cycles", tot, 8);
    check("stream_consecutive_valid", last_run, 8);

    // Reset in the middle of a multiply discards it.
    issue(3'd4, 32'h1234, 32'hFFFFFFFF, model(3'd4, 32'h1234, 32'hFFFFFFFF), nc);
    repeat (9) @(posedge clk);
    #1;
    rst = 1'b0;
    exp_q.delete();
    @(posedge clk); #1;
    rst = 1'b1;
    @(negedge clk);
    check("mid_mul_reset_outputs", 64'({out_valid, Overflow, CarryOut, Zero, Result}), 64'd0);
    check("mid_mul_reset_in_ready", 64'(in_ready), 64'd1);
    outs = 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (out_valid) outs++;
    end
    check("mid_mul_no_stale_result", outs, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
